// File: rtl/multicast_pkg.sv
// Shared types and constants for the multicast router: per-channel FSM states,
// channel indices and the FIFO depth legality check.
package multicast_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CAST = 1'b1
  } cast_state_t;

  localparam int CH_IFMAP = 0;
  localparam int CH_FLTR  = 1;
  localparam int CH_PSUM  = 2;

  // Pointer wrap relies on natural binary overflow, so depth must be 2^n, n >= 1.
  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/multicast_router_cast_fifo.sv
// Synchronous FIFO of {mask, data} entries for one cast channel, with
// full/empty flags and an occupancy count.
module cast_fifo #(
  parameter int DW    = 32,
  parameter int MW    = 4,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic [MW-1:0] push_mask,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output logic [MW-1:0] head_mask,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [MW+DW-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  // A full FIFO refuses a push even when it is popped in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign {head_mask, head_data} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= {push_mask, push_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        cnt <= cnt + 1'b1;
      end else if (do_pop && !do_push) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/multicast_router.sv
// Multicast router: per channel, a FIFO feeds a head register that is broadcast
// to every PE column named in its mask until each column has taken it.
//
// state | meaning
// IDLE  | no head loaded; pops the FIFO when enabled, dropping zero-mask entries
// CAST  | head loaded, at least one masked column still pending delivery
module multicast_router
  import multicast_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COL    = 4,
  parameter int NUM_CH     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                         clk,
  input  logic                                         rstn,
  input  logic [NUM_CH-1:0]                            ch_en,
  input  logic [NUM_CH-1:0]                            in_valid,
  output logic [NUM_CH-1:0]                            in_ready,
  input  logic [NUM_CH-1:0][2*DATA_WIDTH-1:0]          in_data,
  input  logic [NUM_CH-1:0][NUM_COL-1:0]               in_mask,
  output logic [NUM_CH-1:0][2*DATA_WIDTH-1:0]          pe_data,
  output logic [NUM_CH-1:0][NUM_COL-1:0]               pe_valid,
  input  logic [NUM_CH-1:0][NUM_COL-1:0]               pe_ready,
  output logic [NUM_CH-1:0]                            cast_done,
  output logic [NUM_CH-1:0][$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
  output logic                                         busy
);

  localparam int DW2 = 2 * DATA_WIDTH;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  if (!is_pow2(FIFO_DEPTH)) begin : g_bad_depth
    $error("multicast_router: FIFO_DEPTH must be a power of two >= 2");
  end

  logic [NUM_CH-1:0] busy_ch;

  assign busy = |busy_ch;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    cast_state_t        state_q, state_d;
    logic [NUM_COL-1:0] pend_q, pend_d;
    logic [DW2-1:0]     head_q, head_d;
    logic               done_q, done_d;
    logic [NUM_COL-1:0] fire;
    logic               pop;
    logic [DW2-1:0]     push_data;
    logic [DW2-1:0]     f_data;
    logic [NUM_COL-1:0] f_mask;
    logic               f_full;
    logic               f_empty;
    logic [CW-1:0]      f_count;

    // Narrow channels only carry DATA_WIDTH bits; keep the upper half clean.
    if (c == CH_PSUM) begin : g_wide
      assign push_data = in_data[c];
    end else begin : g_narrow
      assign push_data = {{DATA_WIDTH{1'b0}}, in_data[c][DATA_WIDTH-1:0]};
    end

    cast_fifo #(
      .DW    (DW2),
      .MW    (NUM_COL),
      .DEPTH (FIFO_DEPTH),
      .CW    (CW)
    ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (in_valid[c]),
      .push_data (push_data),
      .push_mask (in_mask[c]),
      .pop       (pop),
      .head_data (f_data),
      .head_mask (f_mask),
      .full      (f_full),
      .empty     (f_empty),
      .count     (f_count)
    );

    // Only ch_en gates the registered state/pending; pe_ready never feeds back.
    assign pe_valid[c]   = (state_q == CAST && ch_en[c]) ? pend_q : '0;
    assign fire          = pe_valid[c] & pe_ready[c];
    assign pe_data[c]    = head_q;
    assign cast_done[c]  = done_q;
    assign in_ready[c]   = ~f_full;
    assign fifo_count[c] = f_count;
    assign busy_ch[c]    = (state_q != IDLE) | ~f_empty;

    always_comb begin
      state_d = state_q;
      head_d  = head_q;
      done_d  = 1'b0;
      pop     = 1'b0;
      pend_d  = pend_q & ~fire;
      if (state_q == CAST && pend_d == '0) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      // The head slot is free either in IDLE or on the edge the last column takes it.
      if (pend_d == '0 && !f_empty && ch_en[c]) begin
        pop = 1'b1;
        if (f_mask != '0) begin
          state_d = CAST;
          pend_d  = f_mask;
          head_d  = f_data;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rstn) begin
        state_q <= IDLE;
        pend_q  <= '0;
        head_q  <= '0;
        done_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        pend_q  <= pend_d;
        head_q  <= head_d;
        done_q  <= done_d;
      end
    end
  end

endmodule

// File: tb/tb_multicast_router.sv
// Directed bench for multicast_router: a table of single-entry casts followed by
// hand-written multi-cycle sequences for handshake, backpressure and reset cases.
module tb_multicast_router;

  logic             clk;
  logic             rstn;
  logic [2:0]       ch_en;
  logic [2:0]       in_valid;
  logic [2:0]       in_ready;
  logic [2:0][31:0] in_data;
  logic [2:0][3:0]  in_mask;
  logic [2:0][31:0] pe_data;
  logic [2:0][3:0]  pe_valid;
  logic [2:0][3:0]  pe_ready;
  logic [2:0]       cast_done;
  logic [2:0][2:0]  fifo_count;
  logic             busy;

  int checks = 0;
  int errors = 0;

  multicast_router #(
    .DATA_WIDTH (16),
    .NUM_COL    (4),
    .NUM_CH     (3),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .ch_en      (ch_en),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_mask    (in_mask),
    .pe_data    (pe_data),
    .pe_valid   (pe_valid),
    .pe_ready   (pe_ready),
    .cast_done  (cast_done),
    .fifo_count (fifo_count),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [3:0]  exp_valid;
    logic [31:0] exp_data;
    logic        exp_done;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push1(input int c, input logic [31:0] d, input logic [3:0] m);
    in_valid[c] = 1'b1;
    in_data[c]  = d;
    in_mask[c]  = m;
    tick();
    in_valid[c] = 1'b0;
  endtask

  logic [3:0] ev37[6];
  logic       ed37[6];

  initial begin
    vecs[0] = '{0, 32'h0000_00AB, 4'b1011, 4'b1011, 32'h0000_00AB, 1'b1};
    vecs[1] = '{1, 32'hFFFF_1234, 4'b0001, 4'b0001, 32'h0000_1234, 1'b1};
    vecs[2] = '{2, 32'hDEAD_BEEF, 4'b1111, 4'b1111, 32'hDEAD_BEEF, 1'b1};
    vecs[3] = '{0, 32'h0000_0055, 4'b0000, 4'b0000, 32'h0000_0000, 1'b0};
    vecs[4] = '{2, 32'hFFFF_FFFF, 4'b1000, 4'b1000, 32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{1, 32'h0000_ABCD, 4'b0110, 4'b0110, 32'h0000_ABCD, 1'b1};
    ev37 = '{4'b0000, 4'b0011, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
    ed37 = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    rstn     = 1'b0;
    ch_en    = 3'b111;
    in_valid = '0;
    in_data  = '0;
    in_mask  = '0;
    pe_ready = '0;
    @(negedge clk);
    tick();
    chk("rst_pe_valid", pe_valid, 0);
    chk("rst_pe_data", pe_data, 0);
    chk("rst_cast_done", cast_done, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_busy", busy, 0);
    rstn = 1'b1;
    tick();
    chk("rel_in_ready", in_ready, 3'b111);

    // Single casts with every column ready.
    pe_ready = '1;
    for (int i = 0; i < 6; i++) begin
      push1(vecs[i].ch, vecs[i].data, vecs[i].mask);
      chk($sformatf("v%0d_valid_early", i), pe_valid[vecs[i].ch], 0);
      tick();
      chk($sformatf("v%0d_valid", i), pe_valid[vecs[i].ch], vecs[i].exp_valid);
      if (vecs[i].exp_valid != 0)
        chk($sformatf("v%0d_data", i), pe_data[vecs[i].ch], vecs[i].exp_data);
      chk($sformatf("v%0d_done_early", i), cast_done[vecs[i].ch], 0);
      tick();
      chk($sformatf("v%0d_valid_after", i), pe_valid[vecs[i].ch], 0);
      chk($sformatf("v%0d_done", i), cast_done[vecs[i].ch], vecs[i].exp_done);
      tick();
      chk($sformatf("v%0d_done_clear", i), cast_done[vecs[i].ch], 0);
      chk($sformatf("v%0d_busy", i), busy, 0);
    end

    // Columns served one at a time in order 2,0,3,1; stray ready on cleared columns.
    pe_ready[0] = 4'b0000;
    push1(0, 32'h0000_5A5A, 4'b1111);
    tick();
    chk("ord_valid0", pe_valid[0], 4'b1111);
    pe_ready[0] = 4'b0100;
    tick();
    chk("ord_valid1", pe_valid[0], 4'b1011);
    chk("ord_data1", pe_data[0], 32'h0000_5A5A);
    pe_ready[0] = 4'b0101;
    tick();
    chk("ord_valid2", pe_valid[0], 4'b1010);
    chk("ord_done2", cast_done[0], 0);
    pe_ready[0] = 4'b1000;
    tick();
    chk("ord_valid3", pe_valid[0], 4'b0010);
    chk("ord_data3", pe_data[0], 32'h0000_5A5A);
    pe_ready[0] = 4'b0010;
    tick();
    chk("ord_valid4", pe_valid[0], 4'b0000);
    chk("ord_done4", cast_done[0], 1);
    tick();
    chk("ord_done5", cast_done[0], 0);
    pe_ready[0] = '1;

    // Backpressure on ch1: five pushes, one sits in the head, four queue up.
    pe_ready[1] = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      in_valid[1] = 1'b1;
      in_data[1]  = (i + 1) * 32'h11;
      in_mask[1]  = 4'b0001;
      tick();
    end
    chk("bp_in_ready", in_ready[1], 0);
    chk("bp_count", fifo_count[1], 4);
    chk("bp_head_valid", pe_valid[1], 4'b0001);
    chk("bp_head_data", pe_data[1], 32'h11);
    chk("bp_busy", busy, 1);
    in_data[1] = 32'h66;
    tick();
    chk("bp_reject_count", fifo_count[1], 4);
    in_valid[1] = 1'b0;
    pe_ready[1] = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_drain%0d_valid", i), pe_valid[1], 4'b0001);
      chk($sformatf("bp_drain%0d_data", i), pe_data[1], (i + 1) * 32'h11);
      tick();
    end
    chk("bp_empty_valid", pe_valid[1], 0);
    chk("bp_empty_count", fifo_count[1], 0);
    pe_ready[1] = '1;

    // ch_en[2] dropped for three cycles mid-cast.
    pe_ready[2] = 4'b0000;
    push1(2, 32'hDEAD_BEEF, 4'b0001);
    tick();
    chk("en_valid_pre", pe_valid[2], 4'b0001);
    ch_en[2]    = 1'b0;
    pe_ready[2] = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("en_off%0d_valid", i), pe_valid[2], 0);
      tick();
      chk($sformatf("en_off%0d_done", i), cast_done[2], 0);
    end
    ch_en[2] = 1'b1;
    #1;
    chk("en_on_valid", pe_valid[2], 4'b0001);
    chk("en_on_data", pe_data[2], 32'hDEAD_BEEF);
    tick();
    chk("en_done", cast_done[2], 1);
    chk("en_valid_after", pe_valid[2], 0);
    tick();
    chk("en_done_once", cast_done[2], 0);
    chk("en_valid_once", pe_valid[2], 0);

    // Zero-mask entry sandwiched between two real ones on ch0.
    for (int i = 0; i < 6; i++) begin
      in_valid[0] = (i < 3);
      in_data[0]  = (i == 0) ? 32'h0A0A : (i == 1) ? 32'h0F0F : 32'h0B0B;
      in_mask[0]  = (i == 0) ? 4'b0011  : (i == 1) ? 4'b0000  : 4'b0100;
      tick();
      chk($sformatf("zm%0d_valid", i), pe_valid[0], ev37[i]);
      chk($sformatf("zm%0d_done", i), cast_done[0], ed37[i]);
      if (ev37[i] != 0)
        chk($sformatf("zm%0d_data", i), pe_data[0], (i == 1) ? 32'h0A0A : 32'h0B0B);
    end
    in_valid[0] = 1'b0;

    // Reset with three queued entries and a half-delivered head.
    pe_ready[0] = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = 32'h100 + i;
      in_mask[0]  = 4'b1111;
      tick();
    end
    in_valid[0] = 1'b0;
    chk("mr_count", fifo_count[0], 3);
    chk("mr_valid_full", pe_valid[0], 4'b1111);
    pe_ready[0] = 4'b0011;
    tick();
    chk("mr_valid_half", pe_valid[0], 4'b1100);
    rstn = 1'b0;
    tick();
    chk("mr_rst_valid", pe_valid, 0);
    chk("mr_rst_data", pe_data, 0);
    chk("mr_rst_done", cast_done, 0);
    chk("mr_rst_count", fifo_count, 0);
    chk("mr_rst_busy", busy, 0);
    rstn = 1'b1;
    tick();
    chk("mr_rel_done", cast_done, 0);
    chk("mr_rel_valid", pe_valid, 0);
    chk("mr_rel_ready", in_ready, 3'b111);
    pe_ready[0] = '1;
    push1(0, 32'h0000_0077, 4'b0001);
    tick();
    chk("mr_new_valid", pe_valid[0], 4'b0001);
    chk("mr_new_data", pe_data[0], 32'h0000_0077);
    tick();
    chk("mr_new_done", cast_done[0], 1);
    chk("mr_new_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
